// File: rtl/nn_layer_sequencer_if.sv
// Handshake and datapath-control bundle between the top level and nn_layer_sequencer.
// The master side drives start/mem_ready/eql; the sequencer (slave) drives all the strobes and counters.
interface nn_layer_sequencer_if #(
   parameter int NUM_GROUPS = 3,
   parameter int GROUP_SIZE = 10,
   parameter int ADDR_W     = 10,
   parameter int SEL_W      = $clog2(NUM_GROUPS + 1)
);
   logic                             start;
   logic                             mem_ready;
   logic                             eql;
   logic                             mem_read;
   logic                             input_sel;
   logic                             reg_sel;
   logic [SEL_W-1:0]                 weight_sel;
   logic [SEL_W-1:0]                 bias_sel;
   logic [NUM_GROUPS*GROUP_SIZE-1:0] reg_load;
   logic                             label_mem_read;
   logic                             addr_count_enable;
   logic                             ac_count_enable;
   logic [ADDR_W-1:0]                sample_addr;
   logic [ADDR_W-1:0]                correct_count;
   logic                             busy;
   logic                             done;

   modport master (
      output start, mem_ready, eql,
      input  mem_read, input_sel, reg_sel, weight_sel, bias_sel, reg_load,
             label_mem_read, addr_count_enable, ac_count_enable,
             sample_addr, correct_count, busy, done
   );

   modport slave (
      input  start, mem_ready, eql,
      output mem_read, input_sel, reg_sel, weight_sel, bias_sel, reg_load,
             label_mem_read, addr_count_enable, ac_count_enable,
             sample_addr, correct_count, busy, done
   );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Inference control FSM: NUM_GROUPS hidden-group loads then one output/compare cycle per sample.
// Optional macro ACC_COUNT_EN keeps the correct-prediction counter; otherwise correct_count is tied to 0.
module nn_layer_sequencer #(
   parameter int NUM_GROUPS  = 3,
   parameter int GROUP_SIZE  = 10,
   parameter int NUM_SAMPLES = 750,
   parameter int ADDR_W      = 10,
   parameter int SEL_W       = $clog2(NUM_GROUPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nn_layer_sequencer_if.slave  seq
);

   localparam int                RW     = NUM_GROUPS * GROUP_SIZE;
   localparam logic [SEL_W-1:0]  G_LAST = SEL_W'(NUM_GROUPS - 1);
   localparam logic [SEL_W-1:0]  G_OUT  = SEL_W'(NUM_GROUPS);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NUM_SAMPLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_OUT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  g_q, g_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef ACC_COUNT_EN
   logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

   function automatic logic [RW-1:0] group_mask(input logic [SEL_W-1:0] g);
      logic [RW-1:0] ones;
      ones = RW'({GROUP_SIZE{1'b1}});
      return ones << (int'(g) * GROUP_SIZE);
   endfunction

   always_comb begin
      state_d                = state_q;
      g_d                    = g_q;
      addr_d                 = addr_q;
`ifdef ACC_COUNT_EN
      cnt_d                  = cnt_q;
`endif
      seq.mem_read           = 1'b0;
      seq.input_sel          = 1'b0;
      seq.reg_sel            = 1'b0;
      seq.weight_sel         = '0;
      seq.bias_sel           = '0;
      seq.reg_load           = '0;
      seq.label_mem_read     = 1'b0;
      seq.addr_count_enable  = 1'b0;
      seq.ac_count_enable    = 1'b0;
      seq.busy               = 1'b0;
      seq.done               = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            seq.done = (state_q == S_DONE);
            if (seq.start) begin
               state_d = S_LOAD;
               g_d     = '0;
               addr_d  = '0;
`ifdef ACC_COUNT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            seq.busy       = 1'b1;
            seq.mem_read   = 1'b1;
            seq.input_sel  = 1'b1;
            seq.weight_sel = g_q;
            seq.bias_sel   = g_q;
            // A stalled cycle loads nothing and simply repeats this group.
            if (seq.mem_ready) begin
               seq.reg_load = group_mask(g_q);
               if (g_q == G_LAST) begin
                  state_d = S_OUT;
                  g_d     = '0;
               end else begin
                  g_d = g_q + 1'b1;
               end
            end
         end
         S_OUT: begin
            seq.busy              = 1'b1;
            seq.reg_sel           = 1'b1;
            seq.weight_sel        = G_OUT;
            seq.bias_sel          = G_OUT;
            seq.label_mem_read    = 1'b1;
            seq.addr_count_enable = 1'b1;
            seq.ac_count_enable   = seq.eql;
            addr_d                = addr_q + 1'b1;
`ifdef ACC_COUNT_EN
            if (seq.eql) cnt_d = cnt_q + 1'b1;
`endif
            g_d     = '0;
            state_d = (addr_q == A_LAST) ? S_DONE : S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         g_q     <= '0;
         addr_q  <= '0;
`ifdef ACC_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         addr_q  <= addr_d;
`ifdef ACC_COUNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign seq.sample_addr = addr_q;
`ifdef ACC_COUNT_EN
   assign seq.correct_count = cnt_q;
`else
   assign seq.correct_count = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench for nn_layer_sequencer: per-sample schedules (stalls, eql) expanded into an expected cycle trace.
module tb_nn_layer_sequencer;
   localparam int NG = 3, GS = 10, NS = 4, AW = 10, SW = 2, RW = NG * GS;
`ifdef ACC_COUNT_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   typedef struct {
      bit out;
      int g;
      bit mr;
      bit eq;
   } step_t;

   typedef struct packed {
      logic [11:0]   strb;
      logic [RW-1:0] rl;
      logic [AW-1:0] sa;
      logic [AW-1:0] cc;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   nn_layer_sequencer_if #(.NUM_GROUPS(NG), .GROUP_SIZE(GS), .ADDR_W(AW), .SEL_W(SW)) bus ();

   nn_layer_sequencer #(
      .NUM_GROUPS(NG), .GROUP_SIZE(GS), .NUM_SAMPLES(NS), .ADDR_W(AW), .SEL_W(SW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (bus)
   );

   int    total = 0;
   int    bad   = 0;
   step_t sched[$];
   rec_t  obs[$];
   rec_t  expq[$];

   function automatic rec_t capture();
      rec_t r;
      r.strb = {bus.mem_read, bus.input_sel, bus.reg_sel, bus.weight_sel, bus.bias_sel,
                bus.label_mem_read, bus.addr_count_enable, bus.ac_count_enable, bus.busy, bus.done};
      r.rl   = bus.reg_load;
      r.sa   = bus.sample_addr;
      r.cc   = bus.correct_count;
      return r;
   endfunction

   // eql_mode: 0 = always 1, 1 = alternating 1,0,..., 2 = random
   task automatic make_sched(input int eql_mode, input int stall_max);
      step_t st;
      sched.delete();
      for (int s = 0; s < NS; s++) begin
         for (int g = 0; g < NG; g++) begin
            int n;
            n = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            repeat (n) begin
               st.out = 1'b0; st.g = g; st.mr = 1'b0; st.eq = 1'($urandom);
               sched.push_back(st);
            end
            st.out = 1'b0; st.g = g; st.mr = 1'b1; st.eq = 1'($urandom);
            sched.push_back(st);
         end
         st.out = 1'b1; st.g = 0; st.mr = 1'($urandom);
         st.eq  = (eql_mode == 0) ? 1'b1 : (eql_mode == 1) ? (s % 2 == 0) : 1'($urandom);
         sched.push_back(st);
      end
   endtask

   // Expected outputs per cycle, then the DONE cycle.
   task automatic build_exp();
      int              sa, cc;
      rec_t            r;
      logic [SW-1:0]   gs;
      sa = 0; cc = 0;
      expq.delete();
      foreach (sched[i]) begin
         r    = '0;
         gs   = SW'(sched[i].g);
         if (!sched[i].out) begin
            r.strb = {2'b11, 1'b0, gs, gs, 3'b000, 1'b1, 1'b0};
            if (sched[i].mr)
               for (int b = 0; b < RW; b++) if (b / GS == sched[i].g) r.rl[b] = 1'b1;
         end else begin
            r.strb = {2'b00, 1'b1, SW'(NG), SW'(NG), 1'b1, 1'b1, sched[i].eq, 1'b1, 1'b0};
         end
         r.sa = AW'(sa);
         r.cc = AW'(cc);
         expq.push_back(r);
         if (sched[i].out) begin
            sa++;
            if (ACC_EN && sched[i].eq) cc++;
         end
      end
      r      = '0;
      r.strb = 12'b1;
      r.sa   = AW'(sa);
      r.cc   = AW'(cc);
      expq.push_back(r);
   endtask

   task automatic play(input bit do_start, input bit hold, input int n);
      if (do_start) begin
         @(negedge clk);
         bus.start = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         bus.mem_ready = sched[i].mr;
         bus.eql       = sched[i].eq;
         #1 obs.push_back(capture());
      end
      if (n == sched.size()) begin
         @(negedge clk);
         bus.mem_ready = 1'($urandom);
         bus.eql       = 1'($urandom);
         #1 obs.push_back(capture());
      end
   endtask

   task automatic test_reset();
      rec_t r;
      rst_n = 1'b0;
      bus.start = 1'b1; bus.mem_ready = 1'b1; bus.eql = 1'b1;
      repeat (3) @(negedge clk);
      #1 r = capture();
      total++;
      if (r !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", r); end
      bus.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      #1 r = capture();
      total++;
      if (r !== '0) begin bad++; $display("FAIL idle_after_reset got=%h want=0", r); end
   endtask

   task automatic test_basic();
      logic [RW-1:0] want_rl [3];
      want_rl[0] = 30'h3FF; want_rl[1] = 30'hFFC00; want_rl[2] = 30'h3FF00000;
      make_sched(0, 0); build_exp(); obs.delete();
      play(1'b1, 1'b0, sched.size());
      for (int i = 0; i < expq.size(); i++) begin
         total++;
         if (obs[i] !== expq[i]) begin bad++; $display("FAIL basic_trace cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
      end
      for (int g = 0; g < 3; g++) begin
         total++;
         if (obs[g].rl !== want_rl[g]) begin bad++; $display("FAIL basic_reg_load g=%0d got=%h want=%h", g, obs[g].rl, want_rl[g]); end
      end
      total++;
      if (obs[16].strb[0] !== 1'b1 || obs[15].strb[0] !== 1'b0)
         begin bad++; $display("FAIL basic_done_latency got=%b%b want=01", obs[15].strb[0], obs[16].strb[0]); end
      total++;
      if (obs[16].sa !== AW'(4) || obs[16].cc !== (ACC_EN ? AW'(4) : AW'(0)))
         begin bad++; $display("FAIL basic_counters got=%0d/%0d want=4/%0d", obs[16].sa, obs[16].cc, ACC_EN ? 4 : 0); end
   endtask

   task automatic test_eql_alt();
      int ac, ad;
      make_sched(1, 0); build_exp(); obs.delete();
      play(1'b1, 1'b0, sched.size());
      ac = 0; ad = 0;
      foreach (obs[i]) begin
         total++;
         if (obs[i] !== expq[i]) begin bad++; $display("FAIL alt_trace cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
         ac += int'(obs[i].strb[2]);
         ad += int'(obs[i].strb[3]);
      end
      total++;
      if (ac != 2) begin bad++; $display("FAIL alt_ac_pulses got=%0d want=2", ac); end
      total++;
      if (ad != NS) begin bad++; $display("FAIL alt_addr_pulses got=%0d want=%0d", ad, NS); end
      total++;
      if (obs[obs.size()-1].cc !== (ACC_EN ? AW'(2) : AW'(0)))
         begin bad++; $display("FAIL alt_correct got=%0d want=%0d", obs[obs.size()-1].cc, ACC_EN ? 2 : 0); end
   endtask

   task automatic test_stall();
      step_t st;
      make_sched(0, 0);
      st.out = 1'b0; st.g = 1; st.mr = 1'b0; st.eq = 1'b0;
      repeat (3) sched.insert(1, st);
      build_exp(); obs.delete();
      play(1'b1, 1'b0, sched.size());
      for (int i = 0; i < expq.size(); i++) begin
         total++;
         if (obs[i] !== expq[i]) begin bad++; $display("FAIL stall_trace cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
      end
      total++;
      if (obs[19].strb[0] !== 1'b1 || obs[18].strb[0] !== 1'b0)
         begin bad++; $display("FAIL stall_done_latency got=%b%b want=01", obs[18].strb[0], obs[19].strb[0]); end
   endtask

   task automatic test_random();
      repeat (3) begin
         make_sched(2, 2); build_exp(); obs.delete();
         play(1'b1, 1'b0, sched.size());
         for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[i] !== expq[i]) begin bad++; $display("FAIL random_trace cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      rec_t r;
      make_sched(0, 0); obs.delete();
      play(1'b1, 1'b0, 11);
      @(negedge clk);
      bus.eql = 1'b1; bus.mem_ready = 1'b1; rst_n = 1'b0;
      #1 r = capture();
      total++;
      if (r.strb[3] !== 1'b1 || r.sa !== AW'(2))
         begin bad++; $display("FAIL midrst_in_out got=%b/%0d want=1/2", r.strb[3], r.sa); end
      @(negedge clk);
      rst_n = 1'b1;
      #1 r = capture();
      total++;
      if (r !== '0) begin bad++; $display("FAIL midrst_cleared got=%h want=0", r); end
      repeat (4) begin
         @(negedge clk);
         #1 r = capture();
         total++;
         if (r.strb !== 12'b0) begin bad++; $display("FAIL midrst_idle got=%h want=0", r.strb); end
      end
      make_sched(2, 0); build_exp(); obs.delete();
      play(1'b1, 1'b0, sched.size());
      for (int i = 0; i < expq.size(); i++) begin
         total++;
         if (obs[i] !== expq[i]) begin bad++; $display("FAIL midrst_rerun cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int   n, dn;
      rec_t one[$];
      make_sched(2, 1); build_exp(); obs.delete();
      one = expq;
      foreach (one[i]) expq.push_back(one[i]);
      n = sched.size();
      play(1'b1, 1'b1, n);
      play(1'b0, 1'b1, n);
      bus.start = 1'b0;
      dn = 0;
      for (int i = 0; i < expq.size(); i++) begin
         total++;
         if (obs[i] !== expq[i]) begin bad++; $display("FAIL b2b_trace cyc=%0d got=%h want=%h", i, obs[i], expq[i]); end
         dn += int'(obs[i].strb[0]);
      end
      total++;
      if (dn != 2) begin bad++; $display("FAIL b2b_done_cycles got=%0d want=2", dn); end
      total++;
      if (obs[n+1].strb[1] !== 1'b1 || obs[n+1].sa !== '0 || obs[n+1].cc !== '0)
         begin bad++; $display("FAIL b2b_restart got=%b/%0d/%0d want=1/0/0", obs[n+1].strb[1], obs[n+1].sa, obs[n+1].cc); end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.start = 1'b0; bus.mem_ready = 1'b0; bus.eql = 1'b0; rst_n = 1'b0;
      test_reset();
      test_basic();
      test_eql_alt();
      test_stall();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
